// File: rtl/rr_arbiter16.sv
// 16-requester round-robin arbiter with registered one-hot grant, hold-time limit
// and a one-cycle timeout pulse when a grant is revoked by the hold limit.
module rr_arbiter16 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        enable_i,
   input  logic [15:0] req_i,
   input  logic        release_i,
   output logic [15:0] grant_o,
   output logic [3:0]  grant_id_o,
   output logic        grant_valid_o,
   output logic        timeout_o
);

   localparam int unsigned N     = 16;
   localparam int unsigned IDW   = 4;
   localparam int unsigned HOLDW = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   state_e           state_q;
   logic [IDW-1:0]   rr_ptr_q;
   logic [IDW-1:0]   grant_id_q;
   logic [HOLDW-1:0] hold_q;
   logic [N-1:0]     grant_q;
   logic             grant_valid_q;
   logic             timeout_q;

   logic [IDW-1:0]   win_id_c;
   logic             win_found_c;
   logic [IDW-1:0]   rr_ptr_d;
   logic [HOLDW-1:0] hold_d;
   logic             owner_req_c;
   logic             hold_max_c;
   logic             exit_c;
   logic             timeout_c;

   // First set request searched upward from rr_ptr, wrapping 15 -> 0.
   always_comb begin
      logic [IDW-1:0] cand;
      win_id_c    = rr_ptr_q;
      win_found_c = 1'b0;
      cand        = rr_ptr_q;
      for (int i = 0; i < int'(N); i++) begin
         cand = rr_ptr_q + IDW'(i);
         if (!win_found_c && req_i[cand]) begin
            win_id_c    = cand;
            win_found_c = 1'b1;
         end
      end
   end

   // Exit causes; timeout only counts when no higher-priority cause is present.
   always_comb begin
      owner_req_c = req_i[grant_id_q];
      hold_max_c  = (hold_q == HOLDW'(MAX_HOLD));
      exit_c      = !enable_i || release_i || !owner_req_c || hold_max_c;
      timeout_c   = enable_i && !release_i && owner_req_c && hold_max_c;
      rr_ptr_d    = grant_id_q + IDW'(1);
      hold_d      = hold_q + HOLDW'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         grant_id_q    <= '0;
         hold_q        <= '0;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (enable_i && win_found_c) begin
                  state_q       <= GRANT;
                  grant_id_q    <= win_id_c;
                  grant_q       <= N'(1) << win_id_c;
                  grant_valid_q <= 1'b1;
                  hold_q        <= HOLDW'(1);
               end
            end
            GRANT: begin
               if (exit_c) begin
                  state_q       <= IDLE;
                  rr_ptr_q      <= rr_ptr_d;
                  grant_q       <= '0;
                  grant_valid_q <= 1'b0;
                  hold_q        <= '0;
                  timeout_q     <= timeout_c;
               end else begin
                  hold_q <= hold_d;
               end
            end
            default: begin
               state_q       <= IDLE;
               grant_q       <= '0;
               grant_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign grant_o       = grant_q;
   assign grant_id_o    = grant_id_q;
   assign grant_valid_o = grant_valid_q;
   assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed bench for rr_arbiter16 (MAX_HOLD=4): a per-cycle vector table plus
// hand-written sequences for fairness rotation and asynchronous reset.
module tb_rr_arbiter16;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [15:0] req;
   logic        rel;
   logic [15:0] grant;
   logic [3:0]  grant_id;
   logic        grant_valid;
   logic        timeout;

   int n_checks;
   int n_pass;

   rr_arbiter16 #(.MAX_HOLD(4)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .enable_i     (enable),
      .req_i        (req),
      .release_i    (rel),
      .grant_o      (grant),
      .grant_id_o   (grant_id),
      .grant_valid_o(grant_valid),
      .timeout_o    (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        en;
      logic [15:0] req;
      logic        rel;
      logic        valid;
      logic [3:0]  id;
      logic [15:0] grant;
      logic        tmo;
   } vec_t;

   vec_t vecs[25];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [3:0] id,
                          input logic [15:0] g, input logic t);
      chk({tag, ".valid"},   32'(grant_valid), 32'(v));
      chk({tag, ".id"},      32'(grant_id),    32'(id));
      chk({tag, ".grant"},   32'(grant),       32'(g));
      chk({tag, ".timeout"}, 32'(timeout),     32'(t));
   endtask

   task automatic step(input logic r, input logic e, input logic [15:0] q, input logic l);
      rst = r; enable = e; req = q; rel = l;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      //          rst   en    req       rel   valid id     grant     tmo
      vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 16'h0011, 1'b0, 1'b1, 4'd0,  16'h0001, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 16'h0011, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 16'h0011, 1'b0, 1'b1, 4'd4,  16'h0010, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 16'h0011, 1'b1, 1'b0, 4'd4,  16'h0000, 1'b0};
      // hold limit on requester 15, then wrap back to 15
      vecs[5]  = '{1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 4'd15, 16'h8000, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 4'd15, 16'h8000, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 4'd15, 16'h8000, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 4'd15, 16'h8000, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 4'd15, 16'h0000, 1'b1};
      vecs[10] = '{1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 4'd15, 16'h8000, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 4'd15, 16'h0000, 1'b0};
      // owner 3: release coincides with hold limit -> no timeout, ptr=4
      vecs[12] = '{1'b0, 1'b1, 16'h0008, 1'b0, 1'b1, 4'd3,  16'h0008, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 16'h0008, 1'b0, 1'b1, 4'd3,  16'h0008, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 16'h0008, 1'b0, 1'b1, 4'd3,  16'h0008, 1'b0};
      vecs[15] = '{1'b0, 1'b1, 16'h0008, 1'b0, 1'b1, 4'd3,  16'h0008, 1'b0};
      vecs[16] = '{1'b0, 1'b1, 16'h0008, 1'b1, 1'b0, 4'd3,  16'h0000, 1'b0};
      vecs[17] = '{1'b0, 1'b1, 16'h0018, 1'b0, 1'b1, 4'd4,  16'h0010, 1'b0};
      vecs[18] = '{1'b0, 1'b0, 16'h0018, 1'b0, 1'b0, 4'd4,  16'h0000, 1'b0};
      // owner 7 disabled, no regrant while disabled, then wrapped search finds 7
      vecs[19] = '{1'b0, 1'b1, 16'h0080, 1'b0, 1'b1, 4'd7,  16'h0080, 1'b0};
      vecs[20] = '{1'b0, 1'b0, 16'h0080, 1'b0, 1'b0, 4'd7,  16'h0000, 1'b0};
      vecs[21] = '{1'b0, 1'b0, 16'h0080, 1'b1, 1'b0, 4'd7,  16'h0000, 1'b0};
      vecs[22] = '{1'b0, 1'b0, 16'h0080, 1'b0, 1'b0, 4'd7,  16'h0000, 1'b0};
      vecs[23] = '{1'b0, 1'b1, 16'h0080, 1'b1, 1'b1, 4'd7,  16'h0080, 1'b0};
      vecs[24] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 4'd7,  16'h0000, 1'b0};

      rst = 1'b1; enable = 1'b0; req = '0; rel = 1'b0;
      #1;
      chk_out("async_reset_t0", 1'b0, 4'd0, 16'h0000, 1'b0);

      for (int i = 0; i < 25; i++) begin
         step(vecs[i].rst, vecs[i].en, vecs[i].req, vecs[i].rel);
         chk_out($sformatf("vec%0d", i), vecs[i].valid, vecs[i].id, vecs[i].grant, vecs[i].tmo);
      end

      // Fairness: all requesting, release every grant cycle -> 0..15,0 with gaps.
      step(1'b1, 1'b0, 16'h0000, 1'b0);
      for (int k = 0; k <= 16; k++) begin
         logic [15:0] exp_g;
         logic [3:0]  exp_id;
         exp_id = 4'(k % 16);
         exp_g  = 16'h0001 << exp_id;
         step(1'b0, 1'b1, 16'hFFFF, 1'b1);
         chk_out($sformatf("rot%0d", k), 1'b1, exp_id, exp_g, 1'b0);
         step(1'b0, 1'b1, 16'hFFFF, 1'b1);
         chk_out($sformatf("gap%0d", k), 1'b0, exp_id, 16'h0000, 1'b0);
      end

      // Reset mid-grant of owner 9 drops outputs without waiting for a clock.
      step(1'b1, 1'b0, 16'h0000, 1'b0);
      step(1'b0, 1'b1, 16'h0200, 1'b0);
      chk_out("own9", 1'b1, 4'd9, 16'h0200, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk_out("rst_mid9", 1'b0, 4'd0, 16'h0000, 1'b0);
      @(posedge clk);
      #1;
      chk_out("rst_held", 1'b0, 4'd0, 16'h0000, 1'b0);
      step(1'b0, 1'b1, 16'h0201, 1'b0);
      chk_out("post_rst", 1'b1, 4'd0, 16'h0001, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rr_arbiter16.md
RR_ARBITER16 -- requirements
Module: rr_arbiter16

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, meaning the maximum number of cycles one grant may be held before forced rotation (legal range 1..255).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port enable_i, input, 1, arbiter enable; when low, no new grant is issued.
REQ-005 SHALL have port req_i, input, 16, request vector where bit n is requester n.
REQ-006 SHALL have port release_i, input, 1, the current owner is finished with the resource.
REQ-007 SHALL have port grant_o, output, 16, one-hot grant (1 << grant_id_o), or 16'b0 when no grant.
REQ-008 SHALL have port grant_id_o, output, 4, binary index of the current owner.
REQ-009 SHALL have port grant_valid_o, output, 1, a grant is active.
REQ-010 SHALL have port timeout_o, output, 1, one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-012 IDLE -> GRANT SHALL occur when enable_i=1 and req_i!=0; the winner is the first set bit of req_i searched upward from rr_ptr with wrap 15->0.
REQ-013 Grant latency SHALL be one cycle: a request seen in IDLE at edge k drives grant outputs from edge k+1.
REQ-014 In GRANT, grant_id_o, grant_o and grant_valid_o=1 SHALL be stable and registered; grant_o SHALL always equal the decode of grant_id_o gated by grant_valid_o.
REQ-015 A hold counter SHALL be 1 in the first GRANT cycle and SHALL increment each GRANT cycle; it is 8 bits wide with no wrap (exit occurs first).
REQ-016 GRANT -> IDLE SHALL occur on any of: enable_i=0; release_i=1; req_i[grant_id_o]=0; hold counter == MAX_HOLD.
REQ-017 On every GRANT exit, rr_ptr SHALL become grant_id_o+1 mod 16 (15 wraps to 0), and grant_valid_o/grant_o SHALL be 0 from the next cycle.
REQ-018 After every GRANT exit there SHALL be at least one IDLE cycle; back-to-back grants are separated by exactly one cycle with grant_valid_o=0.
REQ-019 timeout_o SHALL pulse for one cycle, coincident with the first IDLE cycle, only when the exit cause was solely hold counter == MAX_HOLD (no disable, release or request drop in the same cycle).
REQ-020 Simultaneous exit causes SHALL have priority disable > release > request drop > timeout; only the timeout cause asserts timeout_o.
REQ-021 In IDLE with enable_i=0, or with req_i==0, the FSM SHALL stay in IDLE and rr_ptr SHALL be unchanged.
REQ-022 release_i SHALL be ignored in IDLE.
REQ-023 grant_id_o SHALL retain its last value in IDLE; consumers qualify it with grant_valid_o.
REQ-024 Fairness: with all 16 requests continuously asserted and no release, each requester SHALL be granted exactly once per 16 grants, in order.

Reset
REQ-025 While rst_i=1, regardless of clock: state=IDLE, rr_ptr=0, hold counter=0, grant_o=16'b0, grant_id_o=0, grant_valid_o=0, timeout_o=0.
REQ-026 Reset asserted during GRANT SHALL drop the grant immediately (asynchronously), without a timeout_o pulse.
REQ-027 After rst_i deasserts, the first arbitration SHALL search from index 0.

Verification
REQ-028 Reset, then req_i=16'h0011, enable_i=1 -> one cycle later grant_id_o=0, grant_o=16'h0001; release_i pulse -> one IDLE cycle, then grant_id_o=4, grant_o=16'h0010.
REQ-029 MAX_HOLD=4, req_i=16'h8000 held, no release -> grant_valid_o high for exactly 4 cycles, timeout_o pulse in the next cycle, regrant of 15 one cycle later, rr_ptr=0.
REQ-030 req_i=16'hFFFF, release_i asserted in every GRANT cycle -> grant_id_o sequence 0,1,...,15,0 with one-cycle gaps.
REQ-031 Owner 3 active, release_i=1 and hold counter==MAX_HOLD in the same cycle -> exit with timeout_o=0, rr_ptr=4.
REQ-032 Owner 7 active, then enable_i=0 -> grant_o=0 next cycle and no regrant while disabled; enable_i=1 with req_i=16'h0080 -> grant_id_o=7 (search started at 8, wrapped).
REQ-033 rst_i pulsed mid-grant of owner 9 -> outputs 0 immediately; the next grant with req_i=16'h0201 is owner 0.
